// File: rtl/bcd_to_binary2.sv
// Serial packed-BCD to binary converter (reverse double-dabble), one bit per enabled cycle.
// Optional invalid-digit flag built only when BCD_TO_BIN_ERR_CHECK_EN is defined.
//
// state | meaning
// IDLE  | result valid, waiting for start_i
// BUSY  | shifting, one step per ce_i-qualified clock
module bcd_to_binary2 #(
    parameter int BCD_DIGITS_IN_PP   = 6,
    parameter int BITS_OUT_PP        = 20,
    parameter int BIT_COUNT_WIDTH_PP = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ce_i,
    input  logic                          start_i,
    input  logic [4*BCD_DIGITS_IN_PP-1:0] dat_bcd_i,
    output logic [BITS_OUT_PP-1:0]        dat_binary_o,
    output logic                          done_o,
    output logic                          err_o
);

    localparam int BCD_W = 4*BCD_DIGITS_IN_PP;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                        state_q, state_d;
    logic [BCD_W-1:0]              bcd_q, bcd_d, bcd_shift, bcd_adj;
    logic [BITS_OUT_PP-1:0]        bin_q, bin_d, bin_shift;
    logic [BITS_OUT_PP-1:0]        result_q, result_d;
    logic [BIT_COUNT_WIDTH_PP-1:0] count_q, count_d;
    logic                          last_step;
    logic                          unused_lsb;

    // The binary LSB falls off the end of the shift register each step.
    assign unused_lsb = bin_q[0];

    assign {bcd_shift, bin_shift} = {1'b0, bcd_q, bin_q[BITS_OUT_PP-1:1]};
    assign last_step = (count_q == BIT_COUNT_WIDTH_PP'(BITS_OUT_PP-1));

    // A digit >= 8 after the shift carries a spurious 8 that should be 5.
    always_comb begin
        bcd_adj = bcd_shift;
        for (int i = 0; i < BCD_DIGITS_IN_PP; i++) begin
            if (bcd_shift[4*i+3]) begin
                bcd_adj[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        bcd_d    = bcd_q;
        bin_d    = bin_q;
        count_d  = count_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    bcd_d   = dat_bcd_i;
                    bin_d   = '0;
                    count_d = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (ce_i) begin
                    bcd_d   = bcd_adj;
                    bin_d   = bin_shift;
                    count_d = count_q + 1'b1;
                    if (last_step) begin
                        result_d = bin_shift;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            bcd_q    <= '0;
            bin_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            bcd_q    <= bcd_d;
            bin_q    <= bin_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    assign dat_binary_o = result_q;
    assign done_o       = (state_q == IDLE);

`ifdef BCD_TO_BIN_ERR_CHECK_EN
    logic err_flag_q, err_flag_d;
    logic err_q, err_d;

    // Flag is captured at load but only published alongside the result.
    always_comb begin
        err_flag_d = err_flag_q;
        err_d      = err_q;
        if (state_q == IDLE && start_i) begin
            err_flag_d = 1'b0;
            for (int i = 0; i < BCD_DIGITS_IN_PP; i++) begin
                if (dat_bcd_i[4*i +: 4] > 4'd9) begin
                    err_flag_d = 1'b1;
                end
            end
        end
        if (state_q == BUSY && ce_i && last_step) begin
            err_d = err_flag_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_flag_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_flag_q <= err_flag_d;
            err_q      <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary2.sv
// Directed bench for bcd_to_binary2: decimal reference model feeding a result scoreboard.
module tb_bcd_to_binary2;

`ifdef BCD_TO_BIN_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i, ce_i, start_i;
    logic [23:0] dat_bcd_i;
    logic [19:0] dat_binary_o;
    logic        done_o, err_o;

    typedef struct {
        logic [19:0] bin;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk_i = ~clk_i;

    bcd_to_binary2 dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ce_i         (ce_i),
        .start_i      (start_i),
        .dat_bcd_i    (dat_bcd_i),
        .dat_binary_o (dat_binary_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    function automatic logic [19:0] bcd_model(input logic [23:0] b);
        int unsigned v = 0;
        int unsigned p = 1;
        for (int i = 0; i < 6; i++) begin
            v += b[4*i +: 4] * p;
            p *= 10;
        end
        return v[19:0];
    endfunction

    function automatic logic has_bad(input logic [23:0] b);
        logic bad = 1'b0;
        for (int i = 0; i < 6; i++) if (b[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_conv(input logic [23:0] b);
        exp_t e;
        e.bin = bcd_model(b);
        e.err = ERR_EN && has_bad(b);
        sb.push_back(e);
    endtask

    task automatic start_conv(input logic [23:0] b);
        dat_bcd_i = b;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        expect_conv(b);
    endtask

    // Waits for done_o, checking edge count, ce-high count and that the old
    // result is held while busy; then pops and compares the scoreboard.
    task automatic wait_done(input string tag, input bit toggle,
                             input int exp_cyc, input int exp_ce);
        int          n = 0;
        int          ce_hi = 0;
        int          hold_bad = 0;
        logic [19:0] prev = dat_binary_o;
        exp_t        e;
        while (done_o !== 1'b1 && n < 200) begin
            if (dat_binary_o !== prev) hold_bad++;
            if (toggle) ce_i = (n % 2 == 0);
            tick();
            if (ce_i) ce_hi++;
            n++;
        end
        ce_i = 1'b1;
        chk({tag, "_cycles"}, n, exp_cyc);
        chk({tag, "_ce_edges"}, ce_hi, exp_ce);
        chk({tag, "_hold"}, hold_bad, 0);
        chk({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_bin"}, dat_binary_o, e.bin);
            chk({tag, "_err"}, err_o, e.err);
        end
    endtask

    initial begin
        rst_i     = 1'b1;
        ce_i      = 1'b1;
        start_i   = 1'b0;
        dat_bcd_i = '0;
        tick();
        tick();
        rst_i = 1'b0;
        chk("reset_done", done_o, 1'b1);
        chk("reset_bin", dat_binary_o, 20'h0);
        chk("reset_err", err_o, 1'b0);

        // max value
        start_conv(24'h999999);
        wait_done("max", 1'b0, 20, 20);

        // zero then mid value; output must hold 0 during the second
        start_conv(24'h000000);
        wait_done("zero", 1'b0, 20, 20);
        start_conv(24'h123456);
        wait_done("mid", 1'b0, 20, 20);

        // ce toggling 1,0,1,0...
        start_conv(24'h000042);
        wait_done("ce_gate", 1'b1, 39, 20);

        // start pulse with new data at step 7 must be ignored
        start_conv(24'h000100);
        repeat (6) tick();
        dat_bcd_i = 24'h000200;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        wait_done("busy_start", 1'b0, 13, 13);

        // start held through completion: accepted only on the following edge
        dat_bcd_i = 24'h000321;
        start_i   = 1'b1;
        tick();
        expect_conv(24'h000321);
        dat_bcd_i = 24'h000777;
        wait_done("cmpl_edge", 1'b0, 20, 20);
        expect_conv(24'h000777);
        tick();
        chk("restart_busy", done_o, 1'b0);
        start_i = 1'b0;
        wait_done("restart", 1'b0, 20, 20);

        // reset mid-conversion
        start_conv(24'h999999);
        repeat (10) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        sb.delete();
        chk("midrst_done", done_o, 1'b1);
        chk("midrst_bin", dat_binary_o, 20'h0);
        chk("midrst_err", err_o, 1'b0);
        start_conv(24'h000005);
        wait_done("after_rst", 1'b0, 20, 20);

        // invalid digit, then a valid conversion clears the flag
        start_conv(24'h00A001);
        wait_done("bad_digit", 1'b0, 20, 20);
        start_conv(24'h000007);
        wait_done("clear_err", 1'b0, 20, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
